// File: rtl/vga_tile_renderer_pkg.sv
// rtl/vga_tile_renderer_pkg.sv - screen geometry, palette and tile addressing for the tile renderer
package vga_tile_renderer_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int TILE_SIZE    = 8;
  localparam int TILE_COLS    = H_ACTIVE / TILE_SIZE;
  localparam int TILE_ROWS    = V_ACTIVE / TILE_SIZE;
  localparam int MAP_DEPTH    = TILE_COLS * TILE_ROWS;
  localparam int BLINK_FRAMES = 30;
  localparam int RENDER_LAT   = 4;
  localparam logic SYNC_IDLE  = 1'b1;

  typedef logic [11:0] rgb_t;

  // Each palette entry is a foreground/background pair selected by the tile's top two bits.
  function automatic rgb_t pal_color(input logic [1:0] pal, input logic on);
    case (pal)
      2'd0:    pal_color = on ? 12'hFFF : 12'h000;
      2'd1:    pal_color = on ? 12'h0F0 : 12'h000;
      2'd2:    pal_color = on ? 12'hFF0 : 12'h00F;
      default: pal_color = on ? 12'h000 : 12'hF00;
    endcase
  endfunction

  // row*80 + col built from shifts so no multiplier is needed.
  function automatic logic [12:0] tile_addr(input logic [5:0] row, input logic [6:0] col);
    tile_addr = (13'(row) << 6) + (13'(row) << 4) + 13'(col);
  endfunction

endpackage

// File: rtl/vga_tile_renderer_glyph_rom.sv
// rtl/vga_tile_renderer_glyph_rom.sv - 64 glyphs x 8 rows x 8 bits, synchronous read, bit 7 leftmost
module vga_glyph_rom (
  input  logic       clk,
  input  logic [8:0] addr,
  output logic [7:0] data
);

  // Glyph 0 is blank, 1 is a diagonal, 2 is solid; the rest carry an index pattern.
  function automatic logic [7:0] glyph_bits(input logic [5:0] g, input logic [2:0] y);
    case (g)
      6'd0:    glyph_bits = 8'h00;
      6'd1:    glyph_bits = 8'h80 >> y;
      6'd2:    glyph_bits = 8'hFF;
      default: glyph_bits = {g, y[1:0]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    data <= glyph_bits(addr[8:3], addr[2:0]);
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// rtl/vga_tile_renderer.sv - 80x60 tile renderer with blinking cursor and a 4-cycle pixel pipeline
module vga_tile_renderer
  import vga_tile_renderer_pkg::*;
(
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic        blank,
  input  logic        HS,
  input  logic        VS,
  input  logic        wr_en,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out
);

  logic [12:0] s0_addr;
  logic [2:0]  s0_fx, s0_fy, s1_fx, s1_fy, s2_fx;
  logic        s0_active, s1_active, s2_active;
  logic        s0_hit, s1_hit, s2_hit;
  logic        s0_vblank;
  logic [7:0]  s1_tile;
  logic [1:0]  s2_pal;
  logic [7:0]  s2_row;
  logic [RENDER_LAT-1:0] hs_d, vs_d, blank_d;
  logic [4:0]  frame_cnt;
  logic        cursor_phase;
  logic        pix_on;
  rgb_t        rgb_q;
  logic [7:0]  tile_map [MAP_DEPTH];

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      s0_addr   <= '0;
      s0_fx     <= '0;
      s0_fy     <= '0;
      s0_active <= 1'b0;
      s0_hit    <= 1'b0;
      s0_vblank <= 1'b0;
      s1_fx     <= '0;
      s1_fy     <= '0;
      s1_active <= 1'b0;
      s1_hit    <= 1'b0;
      s2_pal    <= '0;
      s2_fx     <= '0;
      s2_active <= 1'b0;
      s2_hit    <= 1'b0;
      hs_d      <= {RENDER_LAT{SYNC_IDLE}};
      vs_d      <= {RENDER_LAT{SYNC_IDLE}};
      blank_d   <= '1;
      rgb_q     <= '0;
    end else begin
      s0_addr   <= tile_addr(vcounter[8:3], hcounter[9:3]);
      s0_fx     <= hcounter[2:0];
      s0_fy     <= vcounter[2:0];
      // Out-of-range counters are treated as blank even if the controller says otherwise.
      s0_active <= !blank && (hcounter < 11'(H_ACTIVE)) && (vcounter < 11'(V_ACTIVE));
      s0_hit    <= cursor_en && (cursor_col < 7'(TILE_COLS)) && (cursor_row < 6'(TILE_ROWS))
                   && (hcounter[9:3] == cursor_col) && (vcounter[8:3] == cursor_row);
      s0_vblank <= (vcounter >= 11'(V_ACTIVE));
      s1_fx     <= s0_fx;
      s1_fy     <= s0_fy;
      s1_active <= s0_active;
      s1_hit    <= s0_hit;
      s2_pal    <= s1_tile[7:6];
      s2_fx     <= s1_fx;
      s2_active <= s1_active;
      s2_hit    <= s1_hit;
      hs_d      <= {hs_d[RENDER_LAT-2:0], HS};
      vs_d      <= {vs_d[RENDER_LAT-2:0], VS};
      blank_d   <= {blank_d[RENDER_LAT-2:0], blank};
      rgb_q     <= s2_active ? pal_color(s2_pal, pix_on) : 12'h000;
    end
  end

  // Read-first tile map: a same-edge write to the read address returns the old byte.
  always_ff @(posedge pixel_clk) begin
    if (wr_en && (wr_addr < 13'(MAP_DEPTH))) begin
      tile_map[wr_addr] <= wr_data;
    end
    s1_tile <= tile_map[s0_addr];
  end

  vga_glyph_rom u_glyph_rom (
    .clk  (pixel_clk),
    .addr ({s1_tile[5:0], s1_fy}),
    .data (s2_row)
  );

  always_comb begin
    pix_on = s2_row[3'd7 - s2_fx] ^ (s2_hit & cursor_phase);
  end

  // Blink bookkeeping only moves on a VS fall inside vertical blank, so a frame never tears.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      frame_cnt    <= '0;
      cursor_phase <= 1'b1;
    end else if (vs_d[1] && !vs_d[0] && s0_vblank) begin
      if (frame_cnt == 5'(BLINK_FRAMES - 1)) begin
        frame_cnt    <= '0;
        cursor_phase <= !cursor_phase;
      end else begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hs_out    = hs_d[RENDER_LAT-1];
  assign vs_out    = vs_d[RENDER_LAT-1];
  assign blank_out = blank_d[RENDER_LAT-1];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb/tb_vga_tile_renderer.sv - self-checking bench for vga_tile_renderer with a screen-level model
module tb_vga_tile_renderer;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcounter = '0;
  logic [10:0] vcounter = '0;
  logic        blank = 1'b1;
  logic        HS = 1'b1;
  logic        VS = 1'b1;
  logic        wr_en = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [5:0]  cursor_row = '0;
  logic [3:0]  red, green, blue;
  logic        hs_out, vs_out, blank_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  vga_tile_renderer dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .hcounter   (hcounter),
    .vcounter   (vcounter),
    .blank      (blank),
    .HS         (HS),
    .VS         (VS),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .blank_out  (blank_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic       active;
    logic [1:0] pal;
    logic       on;
    logic       hit;
    logic       hs;
    logic       vs;
    logic       blank;
  } ent_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
  } out_t;

  localparam ent_t IDLE_E = '{active: 1'b0, pal: 2'd0, on: 1'b0, hit: 1'b0, hs: 1'b1, vs: 1'b1, blank: 1'b1};
  localparam out_t IDLE_O = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, blank: 1'b1};

  logic [11:0] fg_tab [4] = '{12'hFFF, 12'h0F0, 12'hFF0, 12'h000};
  logic [11:0] bg_tab [4] = '{12'h000, 12'h000, 12'h00F, 12'hF00};
  logic [7:0]  mmap [4800];
  ent_t        q [$];
  out_t        cur_exp = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, blank: 1'b1};
  bit          phase = 1'b1;
  int          nfalls = 0;
  logic        prev_vs = 1'b1;

  // Glyph pixels described by shape: 0 empty, 1 the main diagonal, 2 solid.
  function automatic logic glyph_px(input logic [5:0] g, input int x, input int y);
    if (g == 6'd0) return 1'b0;
    if (g == 6'd1) return (x == y);
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 4800; i++) mmap[i] = 8'h00;
    q = {IDLE_E, IDLE_E, IDLE_E};
  end

  always @(posedge pixel_clk) begin
    ent_t e;
    ent_t o;
    int hh, vv, col, row;
    logic [7:0] t;
    if (wr_en && wr_addr < 13'd4800) mmap[wr_addr] = wr_data;
    if (rst) begin
      q       = {IDLE_E, IDLE_E, IDLE_E};
      cur_exp = IDLE_O;
      phase   = 1'b1;
      nfalls  = 0;
      prev_vs = 1'b1;
    end else begin
      hh = int'(hcounter);
      vv = int'(vcounter);
      col = hh / 8;
      row = vv / 8;
      e = IDLE_E;
      e.hs = HS;
      e.vs = VS;
      e.blank = blank;
      e.active = !blank && hh < 640 && vv < 480;
      if (e.active) begin
        t = mmap[row * 80 + col];
        e.pal = t[7:6];
        e.on  = glyph_px(t[5:0], hh % 8, vv % 8);
        e.hit = cursor_en && int'(cursor_col) == col && int'(cursor_row) == row;
      end
      q.push_back(e);
      o = q.pop_front();
      cur_exp.hs = o.hs;
      cur_exp.vs = o.vs;
      cur_exp.blank = o.blank;
      if (!o.active) cur_exp.rgb = 12'h000;
      else if (o.on ^ (o.hit && phase)) cur_exp.rgb = fg_tab[o.pal];
      else cur_exp.rgb = bg_tab[o.pal];
      // Every 30th VS fall seen during vertical blank flips the cursor.
      if (prev_vs && !VS && vv >= 480) begin
        nfalls++;
        if (nfalls % 30 == 0) phase = !phase;
      end
      prev_vs = VS;
    end
  end

  always @(negedge pixel_clk) begin
    out_t e;
    if (chk_en) begin
      e = rst ? IDLE_O : cur_exp;
      check("pix_rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
      check("pix_sync", {29'd0, hs_out, vs_out, blank_out}, {29'd0, e.hs, e.vs, e.blank});
    end
  end

  task automatic drive(input int h, input int v, input logic bl, input logic hs_i, input logic vs_i,
                       input logic we = 1'b0, input int wa = 0, input logic [7:0] wd = 8'h00);
    hcounter = 11'(h);
    vcounter = 11'(v);
    blank    = bl;
    HS       = hs_i;
    VS       = vs_i;
    wr_en    = we;
    wr_addr  = 13'(wa);
    wr_data  = wd;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(700, 500, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic write(input int a, input logic [7:0] d);
    drive(700, 500, 1'b1, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic probe(input string name, input int h, input int v, input logic [11:0] exp);
    drive(h, v, 1'b0, 1'b1, 1'b1);
    idle(3);
    check(name, {20'd0, red, green, blue}, {20'd0, exp});
  endtask

  task automatic scan_line(input int v, input int h_end);
    for (int h = 0; h < h_end; h++)
      drive(h, v, (h >= 640) || (v >= 480), !(h >= 656 && h < 752), !(v == 490 || v == 491));
  endtask

  initial begin
    @(posedge pixel_clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i * 3, 10, 1'b0, i[0], 1'b1);
      check("rst_rgb", {20'd0, red, green, blue}, 32'h0);
      check("rst_sync", {29'd0, hs_out, vs_out, blank_out}, 32'h7);
    end
    rst = 1'b0;
    for (int i = 0; i < 4800; i++) write(i, 8'h00);

    write(0, 8'h01);
    probe("t2_h0", 0, 0, 12'hFFF);
    probe("t2_h1", 1, 0, 12'h000);

    write(4799, 8'h81);
    probe("t3_corner_fg", 632, 472, 12'hFF0);
    probe("t3_corner_bg", 633, 472, 12'h00F);
    write(4800, 8'h02);
    probe("t3_oob_h1", 1, 0, 12'h000);
    probe("t3_oob_h0", 0, 0, 12'hFFF);

    cursor_en = 1'b1;
    cursor_col = 7'd80;
    cursor_row = 6'd0;
    probe("cur_col_oob", 1, 0, 12'h000);
    cursor_col = 7'd0;
    cursor_row = 6'd60;
    probe("cur_row_oob", 1, 0, 12'h000);

    write(0, 8'h00);
    cursor_row = 6'd0;
    for (int f = 0; f < 60; f++) begin
      probe("blink", 3, 2, (f < 30) ? 12'hFFF : 12'h000);
      if (f == 10) begin
        drive(300, 100, 1'b0, 1'b1, 1'b0);
        drive(301, 100, 1'b0, 1'b1, 1'b0);
        drive(302, 100, 1'b0, 1'b1, 1'b1);
      end
      drive(700, 490, 1'b1, 1'b1, 1'b0);
      drive(700, 491, 1'b1, 1'b1, 1'b0);
      drive(700, 492, 1'b1, 1'b1, 1'b1);
    end
    cursor_en = 1'b0;

    write(5, 8'h01);
    drive(41, 0, 1'b0, 1'b1, 1'b1);
    drive(700, 500, 1'b1, 1'b1, 1'b1, 1'b1, 5, 8'h02);
    idle(2);
    check("t6_old", {20'd0, red, green, blue}, 32'h000);
    probe("t6_new", 41, 0, 12'hFFF);

    for (int c = 8; c < 80; c++) write(c, {2'(c), 6'(c % 3)});
    for (int c = 0; c < 79; c++) write(4720 + c, {2'(c + 1), 6'(c % 3)});
    for (int v = 478; v < 496; v++) scan_line(v, 800);
    for (int v = 0; v < 2; v++) scan_line(v, 800);
    scan_line(2, 300);

    rst = 1'b1;
    #1;
    check("rstmid_rgb", {20'd0, red, green, blue}, 32'h0);
    check("rstmid_sync", {29'd0, hs_out, vs_out, blank_out}, 32'h7);
    idle(2);
    rst = 1'b0;
    probe("post_rst", 41, 0, 12'hFFF);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
